// File: rtl/hi_lo_pkg.sv
// Shared definitions for the HI/LO register unit: op encodings,
// default datapath width and the op-validity helper.
package hi_lo_pkg;

    localparam int HILO_WIDTH = 32;

    typedef enum logic [2:0] {
        HILO_NOP  = 3'b000,
        HILO_MULT = 3'b001,
        HILO_MADD = 3'b010,
        HILO_MSUB = 3'b011,
        HILO_MTHI = 3'b100,
        HILO_MTLO = 3'b101
    } hilo_op_e;

    // Codes 110/111 are reserved and treated exactly like NOP.
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op != 3'b000) && (op <= 3'b101);
    endfunction

endpackage

// File: rtl/hi_lo_unit_if.sv
// Bundle of the EX/MEM-side signals feeding the HI/LO unit and the
// HI/LO values plus read hazard it returns.
interface hi_lo_unit_if #(
    parameter int WIDTH = hi_lo_pkg::HILO_WIDTH
);
    logic [2:0]         HiLoOp;
    logic [2*WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0]   RsData;
    logic               HiLoRead;
    logic               Flush;
    logic [WIDTH-1:0]   Hi;
    logic [WIDTH-1:0]   Lo;
    logic               Busy;

    modport master (
        output HiLoOp, ALUResult, RsData, HiLoRead, Flush,
        input  Hi, Lo, Busy
    );

    modport slave (
        input  HiLoOp, ALUResult, RsData, HiLoRead, Flush,
        output Hi, Lo, Busy
    );
endinterface

// File: rtl/hi_lo_accum.sv
// The single 2*WIDTH arithmetic block of the unit: produces the next
// {Hi,Lo} from the current value and the pending op's data.
module hi_lo_accum
    import hi_lo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  hilo_op_e           pOp_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] data_i,
    output logic [2*WIDTH-1:0] result_o
);

    // Select add, subtract or half/full replacement; wraparound is intended.
    always_comb begin
        result_o = acc_i;
        case (pOp_i)
            HILO_MULT: result_o = data_i;
            HILO_MADD: result_o = acc_i + data_i;
            HILO_MSUB: result_o = acc_i - data_i;
            HILO_MTHI: result_o = {data_i[WIDTH-1:0], acc_i[WIDTH-1:0]};
            HILO_MTLO: result_o = {acc_i[2*WIDTH-1:WIDTH], data_i[WIDTH-1:0]};
            default:   result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/hi_lo_unit.sv
// Architectural HI/LO registers behind a one-entry pending stage.
// An op presented in cycle n is captured at edge n and committed at
// edge n+1; Busy tells the hazard unit a read would see stale data.
module hi_lo_unit
    import hi_lo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic       Clk,
    input  logic       Reset,
    hi_lo_unit_if.slave bus
);

    logic               pValid_q, pValid_d;
    hilo_op_e           pOp_q, pOp_d;
    logic [2*WIDTH-1:0] pData_q, pData_d;
    logic [2*WIDTH-1:0] hiLo_q, hiLo_d;
    logic [2*WIDTH-1:0] accResult;
    logic               opValid;

    assign opValid = is_valid_op(bus.HiLoOp);

    hi_lo_accum #(.WIDTH(WIDTH)) uAccum (
        .pOp_i    (pOp_q),
        .acc_i    (hiLo_q),
        .data_i   (pData_q),
        .result_o (accResult)
    );

    // Capture the incoming op into the pending slot unless flushed or a NOP.
    always_comb begin
        pValid_d = 1'b0;
        pOp_d    = HILO_NOP;
        pData_d  = pData_q;
        if (!bus.Flush && opValid) begin
            pValid_d = 1'b1;
            pOp_d    = hilo_op_e'(bus.HiLoOp);
            if (bus.HiLoOp == HILO_MTHI || bus.HiLoOp == HILO_MTLO)
                pData_d = {bus.RsData, bus.RsData};
            else
                pData_d = bus.ALUResult;
        end
    end

    // Commit the pending op against the registered Hi/Lo; a flush freezes them.
    always_comb begin
        hiLo_d = hiLo_q;
        if (pValid_q && !bus.Flush)
            hiLo_d = accResult;
    end

    // State registers; reset drops any pending entry with no partial commit.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pValid_q <= 1'b0;
            pOp_q    <= HILO_NOP;
            pData_q  <= '0;
            hiLo_q   <= '0;
        end else begin
            pValid_q <= pValid_d;
            pOp_q    <= pOp_d;
            pData_q  <= pData_d;
            hiLo_q   <= hiLo_d;
        end
    end

    assign bus.Hi   = hiLo_q[2*WIDTH-1:WIDTH];
    assign bus.Lo   = hiLo_q[WIDTH-1:0];
    assign bus.Busy = Reset & bus.HiLoRead & (pValid_q | opValid);

endmodule

// File: tb/tb_hi_lo_unit.sv
// Self-checking bench for hi_lo_unit: directed scenarios plus a random
// run, all checked against a queue-based model of pending ops.
module tb_hi_lo_unit;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] alu;
        logic [31:0] rs;
    } opItem_t;

    logic Clk;
    logic Reset;
    hi_lo_unit_if #(.WIDTH(32)) bus ();

    hi_lo_unit #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [63:0] mAcc;
    opItem_t     pendQ[$];

    // Free-running 100 MHz-style clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic opIsReal(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    // Retire one op into the model's architectural {Hi,Lo}.
    task automatic applyOp(input opItem_t it);
        case (it.op)
            3'd1: mAcc = it.alu;
            3'd2: mAcc = mAcc + it.alu;
            3'd3: mAcc = mAcc - it.alu;
            3'd4: mAcc[63:32] = it.rs;
            3'd5: mAcc[31:0] = it.rs;
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs, check Busy mid-cycle, then Hi/Lo after the edge.
    task automatic doCycle(input logic [2:0] op, input logic [63:0] alu,
                           input logic [31:0] rs, input logic rd, input logic fl);
        logic    expBusy;
        opItem_t it;
        bus.HiLoOp = op;
        bus.ALUResult = alu;
        bus.RsData = rs;
        bus.HiLoRead = rd;
        bus.Flush = fl;
        #4;
        expBusy = rd && ((pendQ.size() > 0) || opIsReal(op));
        checks++;
        if (bus.Busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL busy op=%0d rd=%0b: got %b expected %b", op, rd, bus.Busy, expBusy);
        end
        @(posedge Clk);
        #1;
        if (fl) begin
            pendQ.delete();
        end else begin
            if (pendQ.size() > 0) applyOp(pendQ.pop_front());
            if (opIsReal(op)) begin
                it.op = op;
                it.alu = alu;
                it.rs = rs;
                pendQ.push_back(it);
            end
        end
        checks++;
        if ({bus.Hi, bus.Lo} !== mAcc) begin
            errors++;
            $display("[TB] FAIL hilo op=%0d fl=%0b: got %h_%h expected %h", op, fl, bus.Hi, bus.Lo, mAcc);
        end
    endtask

    task automatic nop(input logic rd);
        doCycle(3'd0, 64'd0, 32'd0, rd, 1'b0);
    endtask

    task automatic expectHiLo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        checks++;
        if (bus.Hi !== hi || bus.Lo !== lo) begin
            errors++;
            $display("[TB] FAIL %s: got %h_%h expected %h_%h", name, bus.Hi, bus.Lo, hi, lo);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        bus.HiLoOp = 3'd1;
        bus.ALUResult = 64'hDEAD_BEEF_0000_0001;
        bus.RsData = 32'd0;
        bus.HiLoRead = 1'b1;
        bus.Flush = 1'b0;
        mAcc = 64'd0;
        pendQ.delete();
        #3;
        expectHiLo("reset_state", 32'd0, 32'd0);
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.Busy);
        end
        @(posedge Clk);
        #1;
        expectHiLo("reset_hold", 32'd0, 32'd0);
        Reset = 1'b1;
    endtask

    task automatic test_mult;
        doCycle(3'd1, 64'h0000_0002_0000_0003, 32'd0, 1'b0, 1'b0);
        expectHiLo("mult_first_edge", 32'd0, 32'd0);
        nop(1'b0);
        expectHiLo("mult_result", 32'h2, 32'h3);
    endtask

    task automatic test_madd_carry;
        doCycle(3'd1, 64'h0000_0000_0000_0001, 32'd0, 1'b0, 1'b0);
        doCycle(3'd2, 64'h0000_0000_FFFF_FFFF, 32'd0, 1'b0, 1'b0);
        nop(1'b0);
        expectHiLo("madd_carry", 32'h1, 32'h0);
    endtask

    task automatic test_msub_wrap;
        doCycle(3'd1, 64'd0, 32'd0, 1'b0, 1'b0);
        doCycle(3'd3, 64'd1, 32'd0, 1'b0, 1'b0);
        nop(1'b0);
        expectHiLo("msub_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_moves;
        doCycle(3'd4, 64'd0, 32'hAAAA_5555, 1'b0, 1'b0);
        doCycle(3'd5, 64'd0, 32'h1234_ABCD, 1'b0, 1'b0);
        expectHiLo("mthi_lo_untouched", 32'hAAAA_5555, 32'hFFFF_FFFF);
        nop(1'b0);
        expectHiLo("mthi_mtlo", 32'hAAAA_5555, 32'h1234_ABCD);
    endtask

    task automatic test_hazard;
        doCycle(3'd1, 64'h0000_0007_0000_0009, 32'd0, 1'b1, 1'b0);
        nop(1'b1);
        nop(1'b1);
        expectHiLo("hazard_read_sees_product", 32'h7, 32'h9);
        doCycle(3'd6, 64'h1, 32'd1, 1'b1, 1'b0);
        doCycle(3'd7, 64'h1, 32'd1, 1'b1, 1'b0);
        expectHiLo("reserved_no_effect", 32'h7, 32'h9);
    endtask

    task automatic test_flush;
        doCycle(3'd2, 64'h0000_0001_0000_0001, 32'd0, 1'b0, 1'b0);
        doCycle(3'd1, 64'h5555_5555_5555_5555, 32'd0, 1'b1, 1'b1);
        nop(1'b1);
        expectHiLo("flush_hold", 32'h7, 32'h9);
    endtask

    task automatic test_reset_mid;
        doCycle(3'd1, 64'h1111_2222_3333_4444, 32'd0, 1'b0, 1'b0);
        doCycle(3'd2, 64'h0000_0000_0000_0010, 32'd0, 1'b0, 1'b0);
        bus.HiLoOp = 3'd1;
        bus.HiLoRead = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        expectHiLo("reset_mid_clear", 32'd0, 32'd0);
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_busy: got %b expected 0", bus.Busy);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        mAcc = 64'd0;
        pendQ.delete();
        nop(1'b1);
        nop(1'b0);
        expectHiLo("reset_mid_no_commit", 32'd0, 32'd0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            doCycle(3'($urandom_range(0, 7)),
                    {32'($urandom), 32'($urandom)},
                    32'($urandom),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_madd_carry();
        test_msub_wrap();
        test_moves();
        test_hazard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
- Downstream consumer of the 32-bit ALU's 64-bit result in the EX/MEM path; holds the architectural HI and LO registers.
- Commits MULT results, MADD/MSUB accumulations, and MTHI/MTLO moves through a one-entry pending stage.
- Supplies HI/LO to the MFHI/MFLO datapath and raises Busy so the hazard unit stalls a read that would see stale data.

Parameters:
- WIDTH, 32, width of HI, LO and RsData; product/accumulator width is 2*WIDTH.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- HiLoOp  input  3  op for this cycle: 000 NOP, 001 MULT, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 110/111 reserved (= NOP).
- ALUResult  input  2*WIDTH  ALU product; sampled for MULT/MADD/MSUB.
- RsData  input  WIDTH  source operand; sampled for MTHI/MTLO.
- HiLoRead  input  1  an MFHI/MFLO is in the read stage this cycle.
- Flush  input  1  pipeline flush; kills the pending entry and the incoming op.
- Hi  output  WIDTH  architectural HI register.
- Lo  output  WIDTH  architectural LO register.
- Busy  output  1  read hazard; combinational.

Behaviour:
- Reset (Reset=0, async):
  - Hi=0, Lo=0, pending valid=0, pending op=NOP, pending data=0.
  - Busy=0 while in reset.
  - Reset mid-operation discards the pending entry; no partial commit.
- Stage P (pending register), one entry: {PValid, POp[2:0], PData[2*WIDTH-1:0]}.
  - On each edge with Flush=0, if HiLoOp is a valid non-NOP code:
    - PValid<=1, POp<=HiLoOp.
    - PData<=ALUResult for MULT/MADD/MSUB.
    - PData<={RsData,RsData} for MTHI/MTLO.
  - Otherwise PValid<=0.
- Commit stage, on the same edge, if PValid=1 and Flush=0:
  - MULT: {Hi,Lo}<=PData.
  - MADD: {Hi,Lo}<={Hi,Lo}+PData, modulo 2^(2*WIDTH); carry out of bit 2*WIDTH-1 discarded.
  - MSUB: {Hi,Lo}<={Hi,Lo}-PData, modulo 2^(2*WIDTH); borrow discarded.
  - MTHI: Hi<=PData[WIDTH-1:0]; Lo unchanged.
  - MTLO: Lo<=PData[WIDTH-1:0]; Hi unchanged.
- Latency: op presented in cycle n; Hi/Lo show the result after edge n+1 (2 edges).
- Throughput: one op per cycle. Back-to-back MADDs chain correctly because commit uses the registered Hi/Lo updated by the previous commit.
- Simultaneous capture and commit on one edge is the normal case; they are independent.
- Flush=1 at an edge:
  - PValid<=0.
  - Incoming op dropped.
  - Hi/Lo hold, even if PValid was 1.
- Busy = HiLoRead & (PValid | (HiLoOp is a valid non-NOP)). Busy is 0 whenever HiLoRead=0.
- While Busy=1 the consumer stalls and re-presents the read; this block never holds state on Busy.
- Reserved op codes behave exactly as NOP: no capture, and they do not contribute to Busy.
- Hi/Lo are pure register outputs; no combinational path from any input.

Decomposition:
- Package hi_lo_pkg:
  - Op encodings HILO_NOP, HILO_MULT, HILO_MADD, HILO_MSUB, HILO_MTHI, HILO_MTLO.
  - Function is_valid_op.
  - Default WIDTH constant.
- Sub-module hi_lo_accum: combinational 2*WIDTH add/subtract/pass-through selected by POp. It is the only arithmetic; instantiate once.

Test Plan:
- MULT, ALUResult=0x00000002_00000003 → after 2 edges Hi=0x00000002, Lo=0x00000003; Hi/Lo unchanged after the first edge.
- Hi=0,Lo=1; MADD with ALUResult=0x00000000_FFFFFFFF → Hi=0x00000001, Lo=0x00000000 (carry across halves).
- Hi=0,Lo=0; MSUB with ALUResult=1 → Hi=Lo=0xFFFFFFFF (wrap).
- MTHI RsData=0xAAAA5555 then MTLO RsData=0x1234ABCD on consecutive cycles → Hi=0xAAAA5555 and Lo=0x1234ABCD after 3 edges; the MTHI commit leaves Lo untouched.
- Hazard, MULT in cycle n:
  - HiLoRead=1 in cycles n and n+1 → Busy=1 in both.
  - HiLoRead=1 in cycle n+2 → Busy=0 and the read sees the product.
  - HiLoOp=110 with HiLoRead=1 → Busy=0.
- Flush and reset:
  - MADD captured, Flush=1 next cycle → Hi/Lo unchanged, PValid=0.
  - Separately, Reset=0 asserted mid-cycle with PValid=1 → Hi=Lo=0 immediately, and no commit after release.
